// File: rtl/rr_priority_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared definitions for the round-robin priority arbiter:
//                FSM state encoding and a minimum-1 clog2 helper used to
//                size the encoded grant index.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  // One-bit FSM encoding; the GRANT state bit doubles as the valid flag.
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  // Ceiling log2 that never returns less than 1, so an index port always
  // has at least one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_arbiter_if
//  Description : Request/grant bundle between N requesting masters and the
//                arbiter.
//  Ports       : req[N-1:0]        request vector (master -> arbiter)
//                ack               grant accepted (master -> arbiter)
//                gnt_idx[W-1:0]    encoded grant index (arbiter -> master)
//                gnt_onehot[N-1:0] one-hot grant (arbiter -> master)
//                valid             grant active (arbiter -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_priority_arbiter_if #(
  parameter int N = 4
);
  localparam int W = arb_pkg::clog2_min1(N);

  logic [N-1:0] req;
  logic         ack;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;
  logic         valid;

  modport master (
    output req,
    output ack,
    input  gnt_idx,
    input  gnt_onehot,
    input  valid
  );

  modport slave (
    input  req,
    input  ack,
    output gnt_idx,
    output gnt_onehot,
    output valid
  );

endinterface
`default_nettype wire

// File: rtl/rr_priority_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational winner selection. Round-robin mode searches
//                req starting at ptr and wrapping at N; fixed mode picks the
//                highest-index active request.
//  Ports       : req[N-1:0]  request vector
//                ptr[W-1:0]  first index searched in round-robin mode (< N)
//                fixed       1 = MSB-priority selection, ptr ignored
//                idx[W-1:0]  winning index (0 when no request)
//                any         at least one request active
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         fixed,
  output logic [W-1:0] idx,
  output logic         any
);

  localparam logic [2*N-1:0] c_one_dbl = {{(2*N-1){1'b0}}, 1'b1};

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_mask;
  logic [2*N-1:0] w_masked;
  logic [W-1:0]   w_rr_idx;
  logic           w_rr_found;
  logic [W-1:0]   w_fx_idx;

  // Concatenating req with itself turns the wrap-around search into a
  // straight low-to-high scan: bits below ptr in the lower copy are masked,
  // and the upper copy supplies the wrapped part of the order.
  assign w_dbl    = {req, req};
  assign w_mask   = ~((c_one_dbl << ptr) - c_one_dbl);
  assign w_masked = w_dbl & w_mask;

  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!w_rr_found && w_masked[i]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = (i >= N) ? W'(i - N) : W'(i);
      end
    end
  end

  // Last match wins, giving MSB priority.
  always_comb begin
    w_fx_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) w_fx_idx = W'(i);
    end
  end

  assign any = |req;
  assign idx = fixed ? w_fx_idx : w_rr_idx;

endmodule
`default_nettype wire

// File: rtl/rr_priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_arbiter
//  Description : N-way round-robin arbiter with grant lock. A grant stays
//                frozen until acknowledged; on acknowledge the pointer moves
//                past the winner and a new winner is loaded in the same cycle
//                when requests remain. All outputs are registered.
//  Ports       : clk        rising-edge clock
//                reset      asynchronous active-high reset
//                fixed_prio (only with RR_ARB_FIXED_PRIO_EN) 1 = MSB priority
//                bus        rr_priority_arbiter_if.slave request/grant bundle
//  Options     : RR_ARB_FIXED_PRIO_EN adds the fixed_prio input.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                        clk,
  input  logic                        reset,
`ifdef RR_ARB_FIXED_PRIO_EN
  input  logic                        fixed_prio,
`endif
  rr_priority_arbiter_if.slave        bus
);

  localparam int W = clog2_min1(N);
  localparam logic [W-1:0] c_last  = W'(N - 1);
  localparam logic [N-1:0] c_one_n = {{(N-1){1'b0}}, 1'b1};

  logic         r_state;
  logic [W-1:0] r_ptr;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;

  logic         w_state_nxt;
  logic [W-1:0] w_ptr_nxt;
  logic [W-1:0] w_idx_nxt;
  logic [N-1:0] w_onehot_nxt;
  logic         w_accept;
  logic         w_fixed;
  logic [W-1:0] w_pick_idx;
  logic         w_pick_any;

`ifdef RR_ARB_FIXED_PRIO_EN
  // Only consulted when a new winner is loaded, so toggling it during a
  // locked grant has no effect on that grant.
  assign w_fixed = fixed_prio;
`else
  assign w_fixed = 1'b0;
`endif

  // ack only counts while a grant is held.
  assign w_accept = (r_state == ST_GRANT) && bus.ack;

  // Pointer moves past the accepted winner, wrapping at N rather than 2^W.
  // The picker searches from this next pointer so a re-grant after ack sees
  // the rotated priority in the same cycle.
  assign w_ptr_nxt = !w_accept       ? r_ptr :
                     (r_idx == c_last) ? '0  : r_idx + W'(1);

  rr_pick #(
    .N (N)
  ) u_pick (
    .req   (bus.req),
    .ptr   (w_ptr_nxt),
    .fixed (w_fixed),
    .idx   (w_pick_idx),
    .any   (w_pick_any)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_onehot <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_idx    <= w_idx_nxt;
      r_onehot <= w_onehot_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) w_state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (bus.ack) w_state_nxt = w_pick_any ? ST_GRANT : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next grant outputs: load a fresh winner from IDLE or on accept,
  // otherwise hold; zero whenever the arbiter falls back to IDLE.
  always_comb begin
    w_idx_nxt    = r_idx;
    w_onehot_nxt = r_onehot;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_idx_nxt    = w_pick_idx;
          w_onehot_nxt = c_one_n << w_pick_idx;
        end else begin
          w_idx_nxt    = '0;
          w_onehot_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (bus.ack) begin
          if (w_pick_any) begin
            w_idx_nxt    = w_pick_idx;
            w_onehot_nxt = c_one_n << w_pick_idx;
          end else begin
            w_idx_nxt    = '0;
            w_onehot_nxt = '0;
          end
        end
      end
      default: begin
        w_idx_nxt    = '0;
        w_onehot_nxt = '0;
      end
    endcase
  end

  assign bus.valid      = (r_state == ST_GRANT);
  assign bus.gnt_idx    = r_idx;
  assign bus.gnt_onehot = r_onehot;

endmodule
`default_nettype wire

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Parametrised successor to the team's 4-to-2 priority encoder: N request lines, encoded grant index plus one-hot grant and valid flag, all registered.
- Rotating (round-robin) priority with grant lock until acknowledged, so no requester starves.
- Sits between N requesting masters and a single shared resource (bus, memory port, UART TX).

Parameters:
- N, 4, number of request lines; legal range 2..32, non-power-of-2 allowed.
- W, $clog2(N), width of encoded index; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i = requester i wants the resource.
- ack  input  1  resource consumer accepts current grant; sampled only while valid=1.
- gnt_idx  output  W  encoded index of granted requester; 0 when valid=0.
- gnt_onehot  output  N  one-hot grant; all-zero when valid=0.
- valid  output  1  a grant is active.

Behaviour:
- Reset (async, active-high): valid=0, gnt_idx=0, gnt_onehot=0, ptr=0, state=IDLE. Reset mid-grant drops the grant immediately; no ack required afterwards.
- Internal ptr (W bits): first index searched. Search order ptr, ptr+1, ..., N-1, 0, ..., ptr-1; wrap at N, not 2^W.
- States:
  - IDLE: valid=0. If req != 0 at a clock edge, latch the winner and go to GRANT. Latency is 1 cycle from req to valid.
  - GRANT: valid=1. Outputs are frozen until ack=1. Changes on req are ignored while locked, including the granted requester dropping its req.
- GRANT with ack=1:
  - ptr <= (gnt_idx+1) mod N.
  - The winner is recomputed in the same cycle from the current req, searching from the new ptr.
  - If any other or same request is present, stay in GRANT with the new grant on the next cycle (no bubble). Otherwise go to IDLE.
- A requester that wins and still requests after ack is searched last; it wins again only if it is the sole requester.
- ack while valid=0 has no effect.
- gnt_onehot == (1 << gnt_idx) whenever valid=1. Invariant: valid=0 implies both grant outputs are 0.
- ptr changes only on an accepted grant (valid && ack).

Optional Feature:
- Macro: RR_ARB_FIXED_PRIO_EN.
- Defined:
  - Adds input port fixed_prio (1 bit).
  - When fixed_prio=1, the winner is the highest-index active request (MSB priority, as in the 4-to-2 encoder), ignoring ptr. ptr still updates on ack.
  - Changing fixed_prio mid-grant does not disturb the locked grant.
- Undefined: port absent; arbitration is always round-robin.

Decomposition:
- Shared package `arb_pkg`:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - function `clog2_min1` (returns at least 1).
- Sub-module `rr_pick`: purely combinational.
  - Inputs: req[N-1:0], ptr[W-1:0], fixed mode.
  - Outputs: idx[W-1:0], any.
  - Implemented by a double-width masked priority search.
  - Top level holds the FSM, ptr and output registers.

Test Plan:
- Reset/idle: reset=1 with req=4'b1111, then release; req=0 for 3 cycles -> valid=0, gnt_idx=0, gnt_onehot=0 throughout.
- Single-request latency, N=4: req=4'b0100 at edge k -> valid=1, gnt_idx=2, gnt_onehot=4'b0100 after edge k+1; hold ack=0 for 5 cycles and drop req -> outputs unchanged; ack=1 -> valid=0 next cycle, ptr=3.
- Round-robin fairness: req=4'b1111 held, ack=1 every cycle from reset -> gnt_idx sequence 0,1,2,3,0,1 with valid continuously 1 (no bubble).
- Skip and wrap, N=5: ptr=3, req=5'b00101 -> grant 0; after ack, next grant 2; after ack with req=5'b00100 only -> grant 2 again.
- Reset mid-grant: valid=1, gnt_idx=1, assert reset between clock edges -> outputs 0 immediately (asynchronously); after release with req=4'b0010 -> grant 1 from ptr=0.
- With RR_ARB_FIXED_PRIO_EN and fixed_prio=1:
  - req=4'b1001 -> gnt_idx=3.
  - req=4'b0101 -> gnt_idx=2.
  - req=4'b1111 with ack every cycle -> gnt_idx stays 3.
